lzc_expand32: RTL
=================

# lzc_expand32

Sequential expander that rebuilds a 32-bit fixed-point word from its leading-zero-compressed form: a 6-bit leading-zero count plus a 16-bit mantissa. It is the decode side of the leading-zero count and normalization path used for time-of-flight magnitudes. It sits downstream of sample storage and upstream of the TOF arithmetic. It shifts through a multi-cycle coarse/fine right shifter rather than a full barrel shifter, trading latency for area.

## Interface
- W, 32: output word width; only 32 is supported.
- MW, 16: mantissa width; the mantissa is placed at the top of the W-bit word before shifting.
- CW, 6: count width, $clog2(W)+1.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word offered.
- in_ready  out  1  block can accept; high only in IDLE.
- in_lz  in  CW  leading-zero count; legal range 0..32.
- in_mant  in  MW  mantissa; bit MW-1 is normally 1, but this is not checked.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_data  out  W  expanded word.
- out_err  out  1  in_lz was above 32 for this result.

## Operation
- State machine has three states: IDLE, SHIFT, DONE. Internal registers: acc[W-1:0], rem[CW-1:0], err.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: acc={in_mant, (W-MW)'b0}; rem=min(in_lz,32); err=(in_lz>32); next state SHIFT.
- SHIFT, once per cycle:
  - If rem>=8: acc=acc>>8 (logical), rem=rem-8, stay in SHIFT.
  - Else: acc=acc>>rem, rem=0, go to DONE.
  - rem==0 still costs one fine-shift cycle.
- DONE:
  - out_valid=1.
  - On out_ready: go to IDLE.
  - No input is accepted in SHIFT or DONE; there is no IDLE bypass.
- out_data=acc and out_err=err, both registered.
  - They are meaningful only while out_valid=1.
  - They are held stable from DONE entry until the handshake.
  - They keep their last value in IDLE until the next acceptance.
- Arithmetic: result = ({mant,16'b0} >> lz) mod 2^32; lz=32 gives 0.
- Counts 33..63 are treated as 32 (result 0) with out_err=1. They are not rejected.
- A zero mantissa is expanded literally to 0 with out_err=0 (if lz<=32).
- Round-trip property: for x!=0, lz=clz(x) and mant=(x<<lz)[31:16] give x with bits [15-lz:0] cleared (no cleared bits when lz>=16).

## Timing
- Reset values: state=IDLE, in_ready=1 (combinational from state), out_valid=0, out_data=0, out_err=0, rem=0.
- Latency N from the accepting edge to the edge at which out_valid rises: N = floor(min(lz,32)/8)+1.
  - lz 0..7 → 1; lz 8..15 → 2; lz 32 (or >32) → 5.
- Minimum transaction period is N+2 cycles: accept edge, N shift edges, handshake edge back to IDLE.
- out_valid stays high until out_ready is sampled high. The DONE→IDLE edge drops out_valid. in_ready rises in the same cycle.
- in_valid while in_ready=0 is ignored; the producer must hold it.
- Reset asserted mid-SHIFT or in DONE immediately forces the reset values. The transaction is discarded and no output is produced after release.
- Simultaneous in_valid and out_ready in DONE: the output completes and the input is accepted on the following IDLE cycle, not the same edge.

## Test plan
- in_lz=0, in_mant=0xABCD → out_data=0x ABCD0000, out_err=0, out_valid exactly 1 edge after accept.
- in_lz=13, in_mant=0x8001 → out_data=0x00040008, out_err=0, N=2; in_lz=8, in_mant=0xFFFF → 0x00FFFF00, N=2.
- in_lz=32, in_mant=0xFFFF → out_data=0, out_err=0, N=5; in_lz=40 → out_data=0, out_err=1, N=5.
- Backpressure: out_ready low for 10 cycles after DONE with in_valid held high → out_valid stays 1, out_data/out_err stable, in_ready=0, no second accept; then out_ready=1 → in_ready=1 on the next cycle.
- rst_n pulsed low during SHIFT with in_lz=31 → outputs at reset values asynchronously, state IDLE after release, no out_valid pulse.
- 10k random words x fed through a clz reference model (lz=clz(x), mant=(x<<lz)[31:16]), random out_ready stalls → every out_data equals x with bits below 16-lz cleared, ordering preserved, and each accept-to-valid latency equals N.

Source files
------------

// File: rtl/lzc_expand32.sv
// lzc_expand32: rebuilds a 32-bit word from a leading-zero count and 16-bit mantissa via a coarse/fine shifter
module lzc_expand32 #(
    parameter int W  = 32,
    parameter int MW = 16,
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_lz,
    input  logic [MW-1:0] in_mant,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_err
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          err_q, err_d;
    logic          coarse;
    assign coarse    = rem_q >= CW'(8);
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign out_data  = acc_q;
    assign out_err   = err_q;
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        err_d   = err_q;
        if (state_q == IDLE && in_valid) begin
            acc_d   = {in_mant, {(W-MW){1'b0}}};
            rem_d   = in_lz > CW'(W) ? CW'(W) : in_lz;
            err_d   = in_lz > CW'(W);
            state_d = SHIFT;
        end else if (state_q == SHIFT) begin
            // 8-bit steps until fewer than 8 remain, then one fine step (even for 0)
            acc_d   = coarse ? acc_q >> 8 : acc_q >> rem_q;
            rem_d   = coarse ? rem_q - CW'(8) : '0;
            state_d = coarse ? SHIFT : DONE;
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end
endmodule
